// File: rtl/attractor_detector.sv
// Attractor detector: watches a sampled Boolean-network trajectory and reports
// the first recurring state as a fixed point or limit cycle (lambda, mu).
module attractor_detector #(
  parameter  int unsigned STATE_W    = 9,
  parameter  int unsigned HIST_DEPTH = 8,
  parameter  int unsigned TIMEOUT    = 64,
  localparam int unsigned CL_W       = $clog2(HIST_DEPTH + 1),
  localparam int unsigned TL_W       = $clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               state_valid,
  input  logic [STATE_W-1:0] state_in,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic               is_fixed_point,
  output logic [CL_W-1:0]    cycle_len,
  output logic [TL_W-1:0]    transient_len,
  output logic [STATE_W-1:0] attractor_state
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OBSERVE,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [STATE_W-1:0] r_hist [HIST_DEPTH];
  logic [CL_W-1:0]    r_hcnt;
  logic [TL_W-1:0]    r_idx;

  logic               w_match;
  logic [CL_W-1:0]    w_k;
  logic               w_timeout;

  // Parallel compare; scanning downward leaves the smallest matching distance.
  always_comb begin
    w_match = 1'b0;
    w_k     = '0;
    for (int k = HIST_DEPTH; k >= 1; k--) begin
      if ((CL_W'(k) <= r_hcnt) && (r_hist[k-1] == state_in)) begin
        w_match = 1'b1;
        w_k     = CL_W'(k);
      end
    end
  end

  assign w_timeout = (r_idx == TL_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || start) begin
      r_state         <= rst ? S_IDLE : S_OBSERVE;
      busy            <= ~rst;
      for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
      r_hcnt          <= '0;
      r_idx           <= '0;
      done            <= 1'b0;
      found           <= 1'b0;
      is_fixed_point  <= 1'b0;
      cycle_len       <= '0;
      transient_len   <= '0;
      attractor_state <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_OBSERVE: begin
          if (state_valid) begin
            if (w_match) begin
              found           <= 1'b1;
              is_fixed_point  <= (w_k == CL_W'(1));
              cycle_len       <= w_k;
              transient_len   <= r_idx - TL_W'(w_k);
              attractor_state <= state_in;
              done            <= 1'b1;
              busy            <= 1'b0;
              r_state         <= S_DONE;
            end else begin
              for (int i = HIST_DEPTH - 1; i >= 1; i--) r_hist[i] <= r_hist[i-1];
              r_hist[0] <= state_in;
              if (r_hcnt != CL_W'(HIST_DEPTH)) r_hcnt <= r_hcnt + CL_W'(1);
              // idx saturates at TIMEOUT-1; the timeout sample ends the run
              if (w_timeout) begin
                done    <= 1'b1;
                busy    <= 1'b0;
                r_state <= S_DONE;
              end else begin
                r_idx <= r_idx + TL_W'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
